// File: rtl/pc_sequencer_if.sv
// Fetch-sequencer bundle: control inputs, instruction-memory port and datapath hand-off.
interface pc_sequencer_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [31:0] PC;
  logic [31:0] PC_next;
  logic        misaligned;

  modport master (
    input  stall, redirect_valid, redirect_target, trap,
           imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
           PC, PC_next, misaligned
  );

  modport slave (
    output stall, redirect_valid, redirect_target, trap,
           imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
           PC, PC_next, misaligned
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: one outstanding fetch at a time, holds the instruction until the
// datapath consumes it; traps/redirects seen mid-fetch are deferred to data return.
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, r_instr, r_instr_pc, r_pend_tgt;
  logic        r_pend_vld, r_pend_mis, r_misaligned;

  logic [31:0] w_pc_next, w_pc_d, w_instr_d, w_instr_pc_d, w_pend_tgt_d;
  logic        w_pend_vld_d, w_pend_mis_d, w_mis_d;
  logic        w_evt, w_redir_mis, w_evt_mis;

  assign w_evt       = bus.trap | bus.redirect_valid;
  assign w_redir_mis = bus.redirect_valid & (bus.redirect_target[1:0] != 2'b00);
  // A misaligned redirect only reports when it is not masked by a real trap.
  assign w_evt_mis   = ~bus.trap & w_redir_mis;

  always_comb begin
    if (bus.trap || w_redir_mis)  w_pc_next = TRAP_VEC;
    else if (bus.redirect_valid)  w_pc_next = bus.redirect_target;
    else                          w_pc_next = r_pc + 32'd4;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_d       = r_pc;
    w_instr_d    = r_instr;
    w_instr_pc_d = r_instr_pc;
    w_pend_vld_d = r_pend_vld;
    w_pend_tgt_d = r_pend_tgt;
    w_pend_mis_d = r_pend_mis;
    w_mis_d      = 1'b0;
    unique case (r_state)
      IDLE: w_state_nxt = REQ;
      REQ: begin
        if (bus.imem_gnt) begin
          w_state_nxt  = WAIT;
          w_pend_vld_d = w_evt;
          w_pend_tgt_d = w_pc_next;
          w_pend_mis_d = w_evt_mis;
        end else if (w_evt) begin
          w_pc_d  = w_pc_next;
          w_mis_d = w_evt_mis;
        end
      end
      WAIT: begin
        if (w_evt) begin
          w_pend_vld_d = 1'b1;
          w_pend_tgt_d = w_pc_next;
          w_pend_mis_d = w_evt_mis;
        end
        if (bus.imem_rvalid) begin
          if (w_evt || r_pend_vld) begin
            // Returned data belongs to the abandoned path; refetch from the target.
            w_state_nxt  = REQ;
            w_pc_d       = w_evt ? w_pc_next : r_pend_tgt;
            w_mis_d      = w_evt ? w_evt_mis : r_pend_mis;
            w_pend_vld_d = 1'b0;
          end else begin
            w_state_nxt  = HOLD;
            w_instr_d    = bus.imem_rdata;
            w_instr_pc_d = r_pc;
          end
        end
      end
      HOLD: begin
        if (w_evt || (bus.instr_ready && !bus.stall)) begin
          w_state_nxt = REQ;
          w_pc_d      = w_pc_next;
          w_mis_d     = w_evt_mis;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_pc         <= RESET_VEC;
      r_instr      <= 32'd0;
      r_instr_pc   <= 32'd0;
      r_pend_vld   <= 1'b0;
      r_pend_tgt   <= 32'd0;
      r_pend_mis   <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_d;
      r_instr      <= w_instr_d;
      r_instr_pc   <= w_instr_pc_d;
      r_pend_vld   <= w_pend_vld_d;
      r_pend_tgt   <= w_pend_tgt_d;
      r_pend_mis   <= w_pend_mis_d;
      r_misaligned <= w_mis_d;
    end
  end

  assign bus.imem_req    = (r_state == REQ);
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = (r_state == HOLD);
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.PC          = r_pc;
  assign bus.PC_next     = w_pc_next;
  assign bus.misaligned  = r_misaligned;
endmodule
